// File: rtl/ntt_bram_sdp.sv
// Simple-dual-port NTT coefficient RAM: 32-bit lane write enables, write-first collision bypass,
// optional output register, and a hardware zero-fill sequencer that runs after reset or on CLR.
module ntt_bram_sdp #(
   parameter int DW      = 128,
   parameter int WL      = 512,
   parameter int AW      = 13,
   parameter int ASHIFT  = 2,
   parameter int OUT_REG = 0
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_clr,
   output logic               o_busy,
   input  logic               i_wen,
   input  logic [DW/32-1:0]   i_we,
   input  logic [AW-1:0]      i_wa,
   input  logic [DW-1:0]      i_di,
   input  logic               i_ren,
   input  logic [AW-1:0]      i_ra,
   output logic [DW-1:0]      o_do,
   output logic               o_do_vld
);

   localparam int NL = DW / 32;
   localparam int IW = (WL > 1) ? $clog2(WL) : 1;

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t         r_state, w_state_nxt;
   logic [IW-1:0]  r_cnt, w_cnt_nxt;
   logic [DW-1:0]  r_mem [WL];

   logic [AW-1:0]  w_wrow_full, w_rrow_full;
   logic [IW-1:0]  w_wrow, w_rrow;
   logic           w_wr_ok, w_rd_ok, w_idle, w_wr_acc, w_rd_acc, w_coll;
   logic [DW-1:0]  w_rd_dat;
   logic [DW-1:0]  r_do1;
   logic           r_vld1;

   // Range check is done on the full-width row so out-of-range rows never alias onto low rows.
   assign w_wrow_full = i_wa >> ASHIFT;
   assign w_rrow_full = i_ra >> ASHIFT;
   assign w_wr_ok     = (w_wrow_full < AW'(WL));
   assign w_rd_ok     = (w_rrow_full < AW'(WL));
   assign w_wrow      = w_wrow_full[IW-1:0];
   assign w_rrow      = w_rrow_full[IW-1:0];

   assign w_idle   = (r_state == S_IDLE);
   assign o_busy   = (r_state == S_CLEAR);
   assign w_wr_acc = w_idle & i_wen & w_wr_ok & (|i_we);
   assign w_rd_acc = w_idle & i_ren;
   assign w_coll   = w_wr_acc & w_rd_acc & (w_wrow == w_rrow);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_CLEAR: begin
            if (r_cnt == IW'(WL - 1)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_IDLE: begin
            if (i_clr) begin
               w_state_nxt = S_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_CLEAR;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!w_idle) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_acc) begin
         for (int i = 0; i < NL; i++) begin
            if (i_we[i]) r_mem[w_wrow][32*i +: 32] <= i_di[32*i +: 32];
         end
      end
   end

   // Write-first: enabled lanes of a same-row write override the stored word.
   always_comb begin
      w_rd_dat = r_mem[w_rrow];
      if (w_coll) begin
         for (int i = 0; i < NL; i++) begin
            if (i_we[i]) w_rd_dat[32*i +: 32] = i_di[32*i +: 32];
         end
      end
      if (!w_rd_ok) w_rd_dat = '0;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_do1  <= '0;
         r_vld1 <= 1'b0;
      end else begin
         r_vld1 <= w_rd_acc;
         if (w_rd_acc) r_do1 <= w_rd_dat;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DW-1:0] r_do2;
         logic          r_vld2;
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_do2  <= '0;
               r_vld2 <= 1'b0;
            end else begin
               r_vld2 <= r_vld1;
               if (r_vld1) r_do2 <= r_do1;
            end
         end
         assign o_do     = r_do2;
         assign o_do_vld = r_vld2;
      end else begin : g_noreg
         assign o_do     = r_do1;
         assign o_do_vld = r_vld1;
      end
   endgenerate

endmodule

// File: tb/tb_ntt_bram_sdp.sv
// Directed bench: latency-1 and latency-2 instances share one stimulus stream.
module tb_ntt_bram_sdp;

   logic         clk = 1'b0;
   logic         rstn, clr, wen, ren;
   logic [3:0]   we;
   logic [12:0]  wa, ra;
   logic [127:0] di;
   logic         busy0, busy1, vld0, vld1;
   logic [127:0] do0, do1;
   int           checks = 0;
   int           errors = 0;
   int           n;

   always #5 clk = ~clk;

   ntt_bram_sdp #(.OUT_REG(0)) dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .o_busy(busy0),
      .i_wen(wen), .i_we(we), .i_wa(wa), .i_di(di),
      .i_ren(ren), .i_ra(ra), .o_do(do0), .o_do_vld(vld0)
   );

   ntt_bram_sdp #(.OUT_REG(1)) dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .o_busy(busy1),
      .i_wen(wen), .i_we(we), .i_wa(wa), .i_di(di),
      .i_ren(ren), .i_ra(ra), .o_do(do1), .o_do_vld(vld1)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [12:0] a, input logic [3:0] e, input logic [127:0] d);
      wen = 1'b1; we = e; wa = a; di = d;
      @(negedge clk);
      wen = 1'b0; we = '0;
   endtask

   task automatic rd(input logic [12:0] a, input logic [127:0] exp, input string tag);
      ren = 1'b1; ra = a;
      @(negedge clk);
      ren = 1'b0;
      chk({tag, "_vld"}, vld0, 1'b1);
      chk(tag, do0, exp);
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      for (int k = 0; k < 2000; k++) begin
         if (!busy0) break;
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      rstn = 1'b0; clr = 1'b0; wen = 1'b0; ren = 1'b0;
      we = '0; wa = '0; ra = '0; di = '0;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy0, 1'b1);
      chk("rst_vld",  vld0,  1'b0);
      chk("rst_do",   do0,   128'h0);
      chk("rst_vld2", vld1,  1'b0);
      rstn = 1'b1;
      count_busy(n);
      chk("rst_busy_len", n, 512);

      rd(13'h000, 128'h0, "rd_row0");
      rd(13'h3FC, 128'h0, "rd_row255");
      rd(13'h7FC, 128'h0, "rd_row511");

      wr(13'h040, 4'hF, 128'h11111111_22222222_33333333_44444444);
      wr(13'h040, 4'b0101, {4{32'hAAAAAAAA}});
      rd(13'h040, 128'h11111111_AAAAAAAA_33333333_AAAAAAAA, "lane_wr");
      wr(13'h040, 4'b0000, {4{32'h55555555}});
      rd(13'h040, 128'h11111111_AAAAAAAA_33333333_AAAAAAAA, "we0_noop");

      wen = 1'b1; ren = 1'b1; we = 4'b1000; wa = 13'h080; ra = 13'h080;
      di = 128'hDEADBEEF_12345678_12345678_12345678;
      @(negedge clk);
      wen = 1'b0; ren = 1'b0; we = '0;
      chk("coll_vld", vld0, 1'b1);
      chk("coll_do",  do0,  128'hDEADBEEF_00000000_00000000_00000000);
      rd(13'h080, 128'hDEADBEEF_00000000_00000000_00000000, "coll_after");

      for (int k = 0; k < 8; k++) wr(13'(k * 4), 4'hF, 128'(k));
      for (int j = 0; j <= 10; j++) begin
         chk($sformatf("pipe_vld2_%0d", j), vld1, (j >= 2 && j <= 9));
         if (j >= 2) chk($sformatf("pipe_do2_%0d", j), do1, 128'((j - 2 > 7) ? 7 : j - 2));
         chk($sformatf("pipe_vld1_%0d", j), vld0, (j >= 1 && j <= 8));
         if (j >= 1) chk($sformatf("pipe_do1_%0d", j), do0, 128'((j - 1 > 7) ? 7 : j - 1));
         ren = (j < 8);
         ra  = 13'(j * 4);
         @(negedge clk);
      end
      ren = 1'b0;

      wr(13'h028, 4'hF, 128'h5);
      rd(13'h028, 128'h5, "pre_clr_row10");
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_busy", busy0, 1'b1);
      n = 0;
      for (int k = 0; k < 2000; k++) begin
         if (!busy0) break;
         if (n < 32) chk($sformatf("clr_vld_%0d", n), vld0, 1'b0);
         n++;
         clr = (n == 100);
         wen = (n < 30); we = 4'hF; wa = 13'h028; di = 128'h9;
         ren = (n < 30); ra = 13'h028;
         @(negedge clk);
      end
      wen = 1'b0; ren = 1'b0; clr = 1'b0; we = '0;
      chk("clr_busy_len", n, 512);
      rd(13'h028, 128'h0, "post_clr_row10");

      wr(13'h000, 4'hF, {4{32'h77777777}});
      wr(13'h800, 4'hF, {4{32'hFFFFFFFF}});
      rd(13'h000, {4{32'h77777777}}, "oor_nowrap");
      rd(13'h800, 128'h0, "oor_rd");

      ren = 1'b1; ra = 13'h000;
      @(posedge clk);
      #1;
      chk("arst_pre_vld", vld0, 1'b1);
      rstn = 1'b0;
      #1;
      chk("arst_vld",  vld0,  1'b0);
      chk("arst_busy", busy0, 1'b1);
      chk("arst_do",   do0,   128'h0);
      chk("arst_vld2", vld1,  1'b0);
      ren = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      count_busy(n);
      chk("arst_busy_len", n, 512);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
